// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Runs one ALU operation per request. A request (opcode + two operands) is
//   accepted over a valid/ready handshake, the operands and opcode are driven
//   onto the ALU inputs, the block waits the opcode-dependent latency, captures
//   the 64-bit ALU result and returns it over a second valid/ready handshake.
//
// Ports
//   clock, reset_n         : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake; req_op/req_a/req_b sampled at accept
//   alu_y/alu_b/alu_control: registered drive of the ALU inputs
//   alu_result             : ALU output (ALU updates it on the falling edge)
//   rsp_valid/rsp_ready    : response handshake
//   rsp_lo/rsp_hi          : captured result; rsp_hi is 0 for narrow ops
//   rsp_wide/rsp_err       : result came from MUL/DIV / opcode was unsupported
module alu_sequencer #(
    parameter int MULDIV_EXTRA = 2   // legal range 0..15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_control,
    input  logic [63:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_wide,
    output logic        rsp_err
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_INC  = 5'b11111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_supported(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_INC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] alu_y_q, alu_y_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [4:0]  alu_control_q, alu_control_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic        rsp_wide_q, rsp_wide_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cur_wide;

    // alu_control is zero outside EXEC, and stays zero for an unsupported op,
    // so in EXEC it identifies the op in flight.
    assign cur_wide = !err_q && is_wide(alu_control_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        alu_y_d       = alu_y_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_lo_d      = rsp_lo_q;
        rsp_hi_d      = rsp_hi_q;
        rsp_wide_d    = rsp_wide_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = EXEC;
                    if (is_supported(req_op)) begin
                        alu_y_d       = req_a;
                        alu_b_d       = req_b;
                        alu_control_d = req_op;
                        cnt_d         = is_wide(req_op) ? 4'(MULDIV_EXTRA) : 4'd0;
                        err_d         = 1'b0;
                    end else begin
                        cnt_d = 4'd0;
                        err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_lo_d      = err_q ? 32'd0 : alu_result[31:0];
                    rsp_hi_d      = cur_wide ? alu_result[63:32] : 32'd0;
                    rsp_wide_d    = cur_wide;
                    rsp_err_d     = err_q;
                    alu_control_d = 5'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            err_q         <= 1'b0;
            alu_y_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_control_q <= 5'd0;
            rsp_valid_q   <= 1'b0;
            rsp_lo_q      <= 32'd0;
            rsp_hi_q      <= 32'd0;
            rsp_wide_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            alu_y_q       <= alu_y_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_lo_q      <= rsp_lo_d;
            rsp_hi_q      <= rsp_hi_d;
            rsp_wide_q    <= rsp_wide_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign alu_y       = alu_y_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_lo      = rsp_lo_q;
    assign rsp_hi      = rsp_hi_q;
    assign rsp_wide    = rsp_wide_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10010;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_y, alu_b;
    logic [4:0]  alu_control;
    logic [63:0] alu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_lo, rsp_hi;
    logic        rsp_wide, rsp_err;

    int tests = 0;
    int fails = 0;

    alu_sequencer #(.MULDIV_EXTRA(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_y(alu_y), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_wide(rsp_wide), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    // ALU stand-in, updating on the falling edge. Narrow ops put junk in the
    // upper half so the sequencer's zeroing of rsp_hi is observable.
    always @(negedge clock) begin
        case (alu_control)
            OP_ADD:  alu_result <= {32'hDEAD_BEEF, alu_y + alu_b};
            OP_SUB:  alu_result <= {32'hDEAD_BEEF, alu_y - alu_b};
            OP_NOT:  alu_result <= {32'hDEAD_BEEF, ~alu_y};
            OP_MUL:  alu_result <= {32'd0, alu_y} * {32'd0, alu_b};
            OP_DIV:  alu_result <= (alu_b == 0) ? 64'd0 : {alu_y % alu_b, alu_y / alu_b};
            default: alu_result <= 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 5'd0; req_a = 32'd0; req_b = 32'd0;
        #12;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %0b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
        tests++; if ({rsp_lo, rsp_hi} !== 64'd0) begin fails++; $display("FAIL rst_rsp_data got %0h_%0h want 0", rsp_hi, rsp_lo); end
        tests++; if ({rsp_wide, rsp_err} !== 2'b00) begin fails++; $display("FAIL rst_flags got %0b%0b want 00", rsp_wide, rsp_err); end
        tests++; if ({alu_y, alu_b, alu_control} !== 69'd0) begin fails++; $display("FAIL rst_alu got y=%0h b=%0h c=%0h want 0", alu_y, alu_b, alu_control); end
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        present(OP_ADD, 32'd5, 32'd7);
        tick();  // E0
        req_valid = 1'b0;
        tests++; if (alu_control !== OP_ADD) begin fails++; $display("FAIL add_ctrl got %0h want %0h", alu_control, OP_ADD); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL add_busy got %0b want 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid got %0b want 0", rsp_valid); end
        tick();  // E0+1
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %0b want 1", rsp_valid); end
        tests++; if (rsp_lo !== 32'd12) begin fails++; $display("FAIL add_lo got %0d want 12", rsp_lo); end
        tests++; if (rsp_hi !== 32'd0) begin fails++; $display("FAIL add_hi got %0h want 0", rsp_hi); end
        tests++; if ({rsp_wide, rsp_err} !== 2'b00) begin fails++; $display("FAIL add_flags got %0b%0b want 00", rsp_wide, rsp_err); end
        tests++; if (alu_control !== 5'd0) begin fails++; $display("FAIL add_ctrl_idle got %0h want 0", alu_control); end
        drain();
        tests++; if ({rsp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL add_done got v=%0b r=%0b want v=0 r=1", rsp_valid, req_ready); end
    endtask

    task automatic test_mul();
        present(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        tick();  // E0
        req_valid = 1'b0;
        tick();  // E0+1
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mul_valid_e1 got %0b want 0", rsp_valid); end
        tick();  // E0+2
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mul_valid_e2 got %0b want 0", rsp_valid); end
        tick();  // E0+3
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mul_valid_e3 got %0b want 1", rsp_valid); end
        tests++; if ({rsp_hi, rsp_lo} !== 64'h1_0000_0000) begin fails++; $display("FAIL mul_data got %0h_%0h want 1_0", rsp_hi, rsp_lo); end
        tests++; if ({rsp_wide, rsp_err} !== 2'b10) begin fails++; $display("FAIL mul_flags got %0b%0b want 10", rsp_wide, rsp_err); end
        drain();
    endtask

    task automatic test_div();
        present(OP_DIV, 32'd100, 32'd7);
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();  // E0+3
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL div_valid got %0b want 1", rsp_valid); end
        tests++; if ({rsp_hi, rsp_lo} !== {32'd2, 32'd14}) begin fails++; $display("FAIL div_data got %0d/%0d want 2/14", rsp_hi, rsp_lo); end
        tests++; if (rsp_wide !== 1'b1) begin fails++; $display("FAIL div_wide got %0b want 1", rsp_wide); end
        drain();
    endtask

    task automatic test_backpressure();
        present(OP_ADD, 32'd2, 32'd3);
        tick();  // E0
        req_valid = 1'b0;
        tick();  // E0+1, response up
        present(OP_SUB, 32'd9, 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if ({rsp_valid, rsp_lo, rsp_hi, rsp_wide, rsp_err} !== {1'b1, 32'd5, 32'd0, 2'b00}) begin fails++; $display("FAIL bp_hold[%0d] got v=%0b lo=%0d hi=%0h want v=1 lo=5 hi=0", i, rsp_valid, rsp_lo, rsp_hi); end
            tests++; if ({req_ready, alu_control} !== {1'b0, 5'd0}) begin fails++; $display("FAIL bp_noaccept[%0d] got r=%0b c=%0h want r=0 c=0", i, req_ready, alu_control); end
        end
        rsp_ready = 1'b1;
        tick();  // rise edge 1: response handshake only
        rsp_ready = 1'b0;
        tests++; if ({rsp_valid, req_ready, alu_control} !== {2'b01, 5'd0}) begin fails++; $display("FAIL bp_release got v=%0b r=%0b c=%0h want v=0 r=1 c=0", rsp_valid, req_ready, alu_control); end
        tests++; if (rsp_lo !== 32'd5) begin fails++; $display("FAIL bp_lo_kept got %0d want 5", rsp_lo); end
        tick();  // rise edge 2: second request accepted
        req_valid = 1'b0;
        tests++; if ({req_ready, alu_control} !== {1'b0, OP_SUB}) begin fails++; $display("FAIL bp_accept got r=%0b c=%0h want r=0 c=%0h", req_ready, alu_control, OP_SUB); end
        tick();
        tests++; if ({rsp_valid, rsp_lo} !== {1'b1, 32'd5}) begin fails++; $display("FAIL bp_sub got v=%0b lo=%0d want v=1 lo=5", rsp_valid, rsp_lo); end
        drain();
    endtask

    task automatic test_unsupported();
        logic [31:0] y_before;
        y_before = alu_y;
        present(5'b00001, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();  // E0
        req_valid = 1'b0;
        tests++; if (alu_control !== 5'd0) begin fails++; $display("FAIL unsup_ctrl got %0h want 0", alu_control); end
        tests++; if (alu_y !== y_before) begin fails++; $display("FAIL unsup_y got %0h want %0h", alu_y, y_before); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL unsup_busy got %0b want 0", req_ready); end
        tick();  // E0+1
        tests++; if ({rsp_valid, rsp_err, rsp_wide} !== 3'b110) begin fails++; $display("FAIL unsup_flags got v=%0b e=%0b w=%0b want 1 1 0", rsp_valid, rsp_err, rsp_wide); end
        tests++; if ({rsp_hi, rsp_lo} !== 64'd0) begin fails++; $display("FAIL unsup_data got %0h_%0h want 0", rsp_hi, rsp_lo); end
        drain();
    endtask

    task automatic test_reset_mid_div();
        present(OP_DIV, 32'd100, 32'd7);
        tick();  // E0
        req_valid = 1'b0;
        tick();  // E0+1, still waiting
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if ({rsp_valid, req_ready, alu_control} !== {2'b01, 5'd0}) begin fails++; $display("FAIL rstdiv_async got v=%0b r=%0b c=%0h want v=0 r=1 c=0", rsp_valid, req_ready, alu_control); end
        tests++; if ({alu_y, alu_b} !== 64'd0) begin fails++; $display("FAIL rstdiv_ops got %0h %0h want 0", alu_y, alu_b); end
        #4;
        reset_n = 1'b1;
        present(OP_ADD, 32'd1, 32'd1);
        tick();  // first edge after release accepts
        req_valid = 1'b0;
        tests++; if ({rsp_valid, alu_control} !== {1'b0, OP_ADD}) begin fails++; $display("FAIL rstdiv_accept got v=%0b c=%0h want v=0 c=%0h", rsp_valid, alu_control, OP_ADD); end
        tick();
        tests++; if ({rsp_valid, rsp_lo, rsp_hi, rsp_wide} !== {1'b1, 32'd2, 32'd0, 1'b0}) begin fails++; $display("FAIL rstdiv_add got v=%0b lo=%0d hi=%0h w=%0b want 1 2 0 0", rsp_valid, rsp_lo, rsp_hi, rsp_wide); end
        drain();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        present(OP_SUB, 32'd10, 32'd3);
        tick();  // E0: SUB accepted
        present(OP_NOT, 32'd0, 32'd0);
        tick();  // E0+1: capture
        tests++; if ({rsp_valid, rsp_lo} !== {1'b1, 32'd7}) begin fails++; $display("FAIL b2b_sub got v=%0b lo=%0d want v=1 lo=7", rsp_valid, rsp_lo); end
        tick();  // E0+2: handshake
        tests++; if ({rsp_valid, req_ready, alu_control} !== {2'b01, 5'd0}) begin fails++; $display("FAIL b2b_gap got v=%0b r=%0b c=%0h want v=0 r=1 c=0", rsp_valid, req_ready, alu_control); end
        tick();  // E0+3: NOT accepted
        req_valid = 1'b0;
        tests++; if ({req_ready, alu_control} !== {1'b0, OP_NOT}) begin fails++; $display("FAIL b2b_accept got r=%0b c=%0h want r=0 c=%0h", req_ready, alu_control, OP_NOT); end
        tick();  // E0+4
        tests++; if ({rsp_valid, rsp_lo, rsp_hi} !== {1'b1, 32'hFFFF_FFFF, 32'd0}) begin fails++; $display("FAIL b2b_not got v=%0b lo=%0h hi=%0h want 1 ffffffff 0", rsp_valid, rsp_lo, rsp_hi); end
        tick();
        rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_done got %0b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_backpressure();
        test_unsupported();
        test_reset_mid_div();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
